// File: rtl/seq_load_store_if.sv
// Bus bundle for seq_load_store: session control, append/replay requests,
// and the replay/status outputs.
//   slave  : the sequence store (drives dout, dout_vld, count, full, empty,
//            rd_done and, with SEQ_LOAD_STORE_OVF_EN, ovf)
//   master : the game-control side (drives enable, logout, ld, din, rd, rewind)
// Optional feature macro: SEQ_LOAD_STORE_OVF_EN adds the sticky ovf flag.
interface seq_load_store_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             enable;
  logic             logout;
  logic             ld;
  logic [WIDTH-1:0] din;
  logic             rd;
  logic             rewind;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             rd_done;
`ifdef SEQ_LOAD_STORE_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  enable, logout, ld, din, rd, rewind,
    output dout, dout_vld, count, full, empty, rd_done
`ifdef SEQ_LOAD_STORE_OVF_EN
    , output ovf
`endif
  );

  modport master (
    output enable, logout, ld, din, rd, rewind,
    input  dout, dout_vld, count, full, empty, rd_done
`ifdef SEQ_LOAD_STORE_OVF_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/seq_load_store.sv
// seq_load_store: DEPTH-entry sequence register for the memory-tester game.
// Appends symbols in order (ld) and replays them one per cycle (rd/rewind).
// Ports:
//   clk  - clock, all state updates on rising edge
//   rst  - synchronous active-low reset
//   bus  - seq_load_store_if.slave: enable/logout session control,
//          ld/din append, rd/rewind replay, dout/dout_vld registered read
//          data, count/full/empty/rd_done status
// Optional feature macro: SEQ_LOAD_STORE_OVF_EN adds the sticky ovf flag,
// set by any ld while full and cleared only by a clear condition.
module seq_load_store #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  seq_load_store_if.slave   bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    rptr;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             full_c;
  logic             clear_c;
  logic             wr_c;
  logic             rd_ok_c;
`ifdef SEQ_LOAD_STORE_OVF_EN
  logic             ovf;
`endif

  // Clear has priority over everything; logout only matters in-session.
  assign clear_c = !rst || !bus.enable || bus.logout;
  assign full_c  = (count == CW'(DEPTH));
  assign wr_c    = !clear_c && bus.ld && !full_c;
  // Read is judged against pre-edge count, so a same-cycle append is not readable.
  assign rd_ok_c = bus.rd && !bus.rewind && (rptr < count);

  // Storage is never cleared; reads are bounded by count.
  always_ff @(posedge clk) begin
    if (wr_c) mem[IW'(count)] <= bus.din;
  end

  // Pointer, read data and flag state.
  always_ff @(posedge clk) begin
    if (clear_c) begin
      count    <= '0;
      rptr     <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
`ifdef SEQ_LOAD_STORE_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      if (wr_c) count <= count + CW'(1);
`ifdef SEQ_LOAD_STORE_OVF_EN
      if (bus.ld && full_c) ovf <= 1'b1;
`endif
      if (bus.rewind) begin
        rptr     <= '0;
        dout_vld <= 1'b0;
      end else if (rd_ok_c) begin
        dout     <= mem[IW'(rptr)];
        rptr     <= rptr + CW'(1);
        dout_vld <= 1'b1;
      end else begin
        dout_vld <= 1'b0;
      end
    end
  end

  assign bus.dout     = dout;
  assign bus.dout_vld = dout_vld;
  assign bus.count    = count;
  assign bus.full     = full_c;
  assign bus.empty    = (count == '0);
  assign bus.rd_done  = (rptr == count) && (count != '0);
`ifdef SEQ_LOAD_STORE_OVF_EN
  assign bus.ovf      = ovf;
`endif
endmodule

// File: tb/tb_seq_load_store.sv
// Directed self-checking bench for seq_load_store (WIDTH=4, DEPTH=8).
module tb_seq_load_store;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  seq_load_store_if #(.WIDTH(4), .DEPTH(8)) bus ();

  seq_load_store #(.WIDTH(4), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld = 1'b0; bus.rd = 1'b0; bus.rewind = 1'b0; bus.logout = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.enable = 1'b1; idle();
    bus.ld = 1'b1; bus.din = 4'hA;
    step(); step();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    checks++; if (bus.dout !== 4'h0) begin errors++; $display("FAIL reset_dout: got %0h expected 0", bus.dout); end
    checks++; if (bus.dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", bus.dout_vld); end
    checks++; if (bus.rd_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done: got %b expected 0", bus.rd_done); end
`ifdef SEQ_LOAD_STORE_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
`endif
    rst = 1'b1; idle();
  endtask

  task automatic test_fill_replay();
    for (int i = 1; i <= 8; i++) begin
      bus.ld = 1'b1; bus.din = 4'(i);
      step();
      checks++; if (bus.count !== 4'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus.count, i); end
      checks++; if (bus.full !== (i == 8)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, bus.full, (i == 8)); end
    end
    bus.ld = 1'b0;
    bus.rewind = 1'b1; step(); bus.rewind = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.rd = 1'b1;
      step();
      checks++; if (bus.dout !== 4'(i) || bus.dout_vld !== 1'b1) begin errors++; $display("FAIL replay[%0d]: got dout=%0h vld=%b expected dout=%0h vld=1", i, bus.dout, bus.dout_vld, i); end
    end
    checks++; if (bus.rd_done !== 1'b1) begin errors++; $display("FAIL replay_rd_done: got %b expected 1", bus.rd_done); end
    step();
    checks++; if (bus.dout_vld !== 1'b0 || bus.dout !== 4'h8) begin errors++; $display("FAIL replay_extra_rd: got dout=%0h vld=%b expected dout=8 vld=0", bus.dout, bus.dout_vld); end
    bus.rd = 1'b0;
  endtask

  task automatic test_overflow();
    bus.ld = 1'b1; bus.din = 4'hF; step(); bus.ld = 1'b0;
    checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin errors++; $display("FAIL ovf_count: got count=%0d full=%b expected 8/1", bus.count, bus.full); end
`ifdef SEQ_LOAD_STORE_OVF_EN
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.ovf); end
    step();
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_held: got %b expected 1", bus.ovf); end
`endif
    bus.rewind = 1'b1; step(); bus.rewind = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.rd = 1'b1;
      step();
      checks++; if (bus.dout !== 4'(i)) begin errors++; $display("FAIL ovf_replay[%0d]: got %0h expected %0h", i, bus.dout, i); end
    end
    bus.rd = 1'b0;
    bus.logout = 1'b1; step(); bus.logout = 1'b0;
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.dout !== 4'h0) begin errors++; $display("FAIL ovf_logout: got count=%0d empty=%b dout=%0h expected 0/1/0", bus.count, bus.empty, bus.dout); end
`ifdef SEQ_LOAD_STORE_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b expected 0", bus.ovf); end
`endif
  endtask

  task automatic test_simultaneous();
    for (int i = 1; i <= 3; i++) begin
      bus.ld = 1'b1; bus.din = 4'(i); step();
    end
    bus.ld = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.rd = 1'b1; step();
    end
    checks++; if (bus.dout !== 4'h3 || bus.rd_done !== 1'b1) begin errors++; $display("FAIL sim_setup: got dout=%0h rd_done=%b expected 3/1", bus.dout, bus.rd_done); end
    bus.ld = 1'b1; bus.din = 4'h5; bus.rd = 1'b1; step(); bus.ld = 1'b0;
    checks++; if (bus.count !== 4'd4 || bus.dout_vld !== 1'b0 || bus.dout !== 4'h3) begin errors++; $display("FAIL sim_ld_rd: got count=%0d vld=%b dout=%0h expected 4/0/3", bus.count, bus.dout_vld, bus.dout); end
    step();
    checks++; if (bus.dout !== 4'h5 || bus.dout_vld !== 1'b1) begin errors++; $display("FAIL sim_next_rd: got dout=%0h vld=%b expected 5/1", bus.dout, bus.dout_vld); end
    bus.rewind = 1'b1; step(); bus.rewind = 1'b0;
    checks++; if (bus.dout_vld !== 1'b0 || bus.dout !== 4'h5 || bus.rd_done !== 1'b0) begin errors++; $display("FAIL sim_rewind_rd: got vld=%b dout=%0h rd_done=%b expected 0/5/0", bus.dout_vld, bus.dout, bus.rd_done); end
    step();
    checks++; if (bus.dout !== 4'h1 || bus.dout_vld !== 1'b1) begin errors++; $display("FAIL sim_after_rewind: got dout=%0h vld=%b expected 1/1", bus.dout, bus.dout_vld); end
    bus.rd = 1'b0;
  endtask

  task automatic test_session_abort();
    bus.rewind = 1'b1; step(); bus.rewind = 1'b0;
    bus.rd = 1'b1; step(); step();
    checks++; if (bus.dout !== 4'h2) begin errors++; $display("FAIL abort_setup: got %0h expected 2", bus.dout); end
    bus.enable = 1'b0; step();
    checks++; if (bus.count !== 4'd0 || bus.dout !== 4'h0 || bus.dout_vld !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL abort_clear: got count=%0d dout=%0h vld=%b empty=%b expected 0/0/0/1", bus.count, bus.dout, bus.dout_vld, bus.empty); end
    bus.enable = 1'b1; step();
    checks++; if (bus.dout_vld !== 1'b0 || bus.dout !== 4'h0) begin errors++; $display("FAIL abort_rd: got vld=%b dout=%0h expected 0/0", bus.dout_vld, bus.dout); end
    bus.rd = 1'b0; bus.ld = 1'b1; bus.din = 4'h7; step(); bus.ld = 1'b0;
    bus.rd = 1'b1; step(); bus.rd = 1'b0;
    checks++; if (bus.dout !== 4'h7 || bus.dout_vld !== 1'b1) begin errors++; $display("FAIL abort_rptr0: got dout=%0h vld=%b expected 7/1", bus.dout, bus.dout_vld); end
  endtask

  task automatic test_logout_gating();
    bus.enable = 1'b0; bus.logout = 1'b1; bus.ld = 1'b1; bus.din = 4'h9;
    step(); step();
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL gate_disabled: got count=%0d empty=%b expected 0/1", bus.count, bus.empty); end
    bus.enable = 1'b1; step();
    checks++; if (bus.count !== 4'd0 || bus.dout_vld !== 1'b0) begin errors++; $display("FAIL gate_logout_ld: got count=%0d vld=%b expected 0/0", bus.count, bus.dout_vld); end
    bus.logout = 1'b0; step(); bus.ld = 1'b0;
    checks++; if (bus.count !== 4'd1 || bus.empty !== 1'b0) begin errors++; $display("FAIL gate_resume: got count=%0d empty=%b expected 1/0", bus.count, bus.empty); end
  endtask

  initial begin
    bus.din = '0;
    test_reset();
    test_fill_replay();
    test_overflow();
    test_simultaneous();
    test_session_abort();
    test_logout_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_load_store.md
# seq_load_store

Parametrised sequence register for the memory-tester game: it generalises the single 4-bit load register into a DEPTH-entry store that records a player's or generator's symbol sequence in order and replays it for comparison. It sits between the input/debounce logic and the game-control FSM, which appends entries with `ld` and replays them with `rd`/`rewind`. Session control (`enable`, `logout`) clears it exactly as the single register is cleared today.

## Interface
- WIDTH, 4: bits per entry (1..16)
- DEPTH, 8: number of entries (2..32); CW = $clog2(DEPTH+1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- enable  in  1  session active; 0 clears the block every cycle
- logout  in  1  clear request, honoured only while enable=1
- ld  in  1  append din at write pointer
- din  in  WIDTH  entry to append
- rd  in  1  read entry at read pointer and advance
- rewind  in  1  read pointer back to 0
- dout  out  WIDTH  last entry read (registered)
- dout_vld  out  1  one-cycle strobe: dout updated this cycle
- count  out  CW  entries stored
- full  out  1  count==DEPTH
- empty  out  1  count==0
- rd_done  out  1  read pointer == count and count!=0
- ovf  out  1  sticky overflow (only with SEQ_LOAD_STORE_OVF_EN)

## Operation
- State: storage array mem[DEPTH], wptr/count (CW bits, wptr==count), rptr (CW bits), dout, dout_vld, ovf.
- Priority per edge: rst==0 > enable==0 > logout==1 > normal ops.
- Clear (rst low, enable low, or logout with enable high): count=0, rptr=0, dout=0, dout_vld=0, ovf=0. mem contents not cleared; never visible since reads are bounded by count.
- Append: ld=1 and count<DEPTH -> mem[count]<=din, count<=count+1. ld=1 and full -> write dropped, count held (ovf set if compiled in).
- Read: rd=1, rewind=0, rptr<count (pre-edge count) -> dout<=mem[rptr], rptr<=rptr+1, dout_vld<=1. rd with rptr==count -> ignored, dout held, dout_vld<=0.
- dout_vld is 0 every cycle without a successful read.
- rewind=1 -> rptr<=0; any same-cycle rd ignored; dout held.
- ld and rd same cycle: both execute; read uses pre-edge count, so an entry being written this cycle is not readable until the next cycle.
- ld and rewind same cycle: both execute.
- full, empty, rd_done: combinational from registered count/rptr.

## Timing
- Reset/clear values: dout=0, dout_vld=0, count=0, full=0, empty=1, rd_done=0, ovf=0.
- Append latency: count/full/empty update on the edge that samples ld.
- Read latency: 1 cycle; rd sampled at edge N -> dout/dout_vld valid after edge N; back-to-back rd streams one entry per cycle.
- Clear takes effect on the sampling edge; logout or enable drop mid-replay aborts immediately, with no further dout_vld.
- No hold requirement on inputs beyond one sampled cycle.

## Configuration
- SEQ_LOAD_STORE_OVF_EN defined: `ovf` port present; set on any ld while full; held until clear. Cleared only by rst, enable low, or logout.
- Not defined: no `ovf` port; ld while full silently dropped, all other behaviour identical.

## Test plan
- Reset: rst=0 for 2 cycles with ld=1, din=4'hA -> count=0, empty=1, dout=0, dout_vld=0.
- Fill/replay, WIDTH=4 DEPTH=8: append 1..8 -> full=1 after 8th edge. rewind, then 8 consecutive rd -> dout 1..8 on successive cycles with dout_vld=1. rd_done=1 after the last read; a 9th rd gives dout_vld=0 and dout=8.
- Overflow: when full, ld din=4'hF -> count stays 8, mem unchanged on replay. With macro, ovf=1 and held; logout -> ovf=0, count=0.
- Simultaneous events: count=3, rptr=3, ld=1 din=5 and rd=1 same cycle -> count=4, dout_vld=0. Next-cycle rd -> dout=5. rewind+rd same cycle -> rptr=0, dout_vld=0.
- Session abort: mid-replay at rptr=2, enable=0 one cycle -> count=0, rptr=0, dout=0. With enable=1, a following rd -> dout_vld=0.
- Logout gating: enable=0 with logout=1 -> held clear. enable=1, logout=1, ld=1 same cycle -> clear wins, count=0.
